freq_gate_ctrl: RTL and testbench

FREQ_GATE_CTRL -- requirements
Module: freq_gate_ctrl

---
 rtl/freq_gate_ctrl.sv | 134 +++++++++++++
 tb/tb_freq_gate_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/freq_gate_ctrl.sv
// Gate/sequence controller for a reciprocal-free frequency counter.
// Synchronises the measured signal, turns its rising edges into one-cycle
// increment pulses for an external BCD decade counter during a fixed gate,
// then latches the counter value and an overflow flag for a display consumer
// through a valid/ready handshake.
module freq_gate_ctrl #(
    parameter int DIGITS_NUM  = 6,
    parameter int GATE_CYCLES = 1000000
) (
    input  logic                      clk_in,
    input  logic                      reset_in,
    input  logic                      signal_in,
    input  logic [4*DIGITS_NUM-1:0]   digits_in,
    input  logic                      carry_in,
    output logic                      count_enable_out,
    output logic                      count_clear_out,
    output logic [4*DIGITS_NUM-1:0]   result_out,
    output logic                      overflow_out,
    output logic                      result_valid_out,
    input  logic                      result_ready_in
);

    localparam int TW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(GATE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_CLEAR  = 2'd0,
        ST_GATE   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_LATCH  = 2'd3
    } state_e;

    state_e                    state_q;
    state_e                    state_d;
    logic [TW-1:0]             timer_q;
    logic [TW-1:0]             timer_d;
    logic [2:0]                sync_q;
    logic                      edge_s;
    logic                      count_enable_q;
    logic                      count_clear_q;
    logic                      ovf_acc_q;
    logic [4*DIGITS_NUM-1:0]   result_q;
    logic                      overflow_q;
    logic                      valid_q;

    // Rising edge of the synchronised input; bit 2 is the delayed copy.
    assign edge_s = sync_q[1] & ~sync_q[2];

    // Next-state and gate-timer logic for the free-running measurement cycle.
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            ST_CLEAR: begin
                state_d = ST_GATE;
                timer_d = '0;
            end
            ST_GATE: begin
                if (timer_q == TIMER_LAST) begin
                    state_d = ST_SETTLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ST_SETTLE: begin
                state_d = ST_LATCH;
            end
            ST_LATCH: begin
                state_d = ST_CLEAR;
            end
            default: begin
                state_d = ST_CLEAR;
                timer_d = '0;
            end
        endcase
    end

    // FSM state, gate timer, input synchroniser and registered counter controls.
    // Enable/clear are computed from the next state so they line up with it;
    // edges whose pulse would fall outside GATE are dropped, never deferred.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q        <= ST_CLEAR;
            timer_q        <= '0;
            sync_q         <= 3'b000;
            count_enable_q <= 1'b0;
            count_clear_q  <= 1'b1;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            sync_q         <= {sync_q[1:0], signal_in};
            count_enable_q <= edge_s & (state_d == ST_GATE);
            count_clear_q  <= (state_d == ST_CLEAR);
        end
    end

    // Overflow accumulator: any carry seen together with an increment in GATE.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            ovf_acc_q <= 1'b0;
        end else if (state_q == ST_CLEAR) begin
            ovf_acc_q <= 1'b0;
        end else if ((state_q == ST_GATE) && carry_in && count_enable_q) begin
            ovf_acc_q <= 1'b1;
        end else begin
            ovf_acc_q <= ovf_acc_q;
        end
    end

    // Result latch and valid flag; a new LATCH always wins over a handshake.
    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            result_q   <= '0;
            overflow_q <= 1'b0;
            valid_q    <= 1'b0;
        end else if (state_q == ST_LATCH) begin
            result_q   <= digits_in;
            overflow_q <= ovf_acc_q;
            valid_q    <= 1'b1;
        end else if (valid_q && result_ready_in) begin
            valid_q    <= 1'b0;
        end else begin
            valid_q    <= valid_q;
        end
    end

    assign count_enable_out = count_enable_q;
    assign count_clear_out  = count_clear_q;
    assign result_out       = result_q;
    assign overflow_out     = overflow_q;
    assign result_valid_out = valid_q;

endmodule

// File: tb/tb_freq_gate_ctrl.sv
// Directed bench for freq_gate_ctrl with a 2-digit BCD counter model.
module tb_freq_gate_ctrl;

    localparam int G = 100;
    localparam int D = 2;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         man_sig = 1'b0;
    logic         gen_sig = 1'b0;
    logic         sig;
    logic         carry;
    logic         force_carry = 1'b0;
    logic         ready = 1'b0;
    logic [7:0]   digits = 8'h00;
    logic         en;
    logic         clr;
    logic [7:0]   result;
    logic         ovf;
    logic         valid;

    int period = 0;
    int ph = 0;
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign sig   = (period == 0) ? man_sig : gen_sig;
    assign carry = (digits == 8'h99) | force_carry;

    freq_gate_ctrl #(.DIGITS_NUM(D), .GATE_CYCLES(G)) dut (
        .clk_in           (clk),
        .reset_in         (rst_n),
        .signal_in        (sig),
        .digits_in        (digits),
        .carry_in         (carry),
        .count_enable_out (en),
        .count_clear_out  (clr),
        .result_out       (result),
        .overflow_out     (ovf),
        .result_valid_out (valid),
        .result_ready_in  (ready)
    );

    function automatic logic [7:0] bcd_inc(input logic [7:0] d);
        logic [3:0] lo;
        logic [3:0] hi;
        lo = d[3:0];
        hi = d[7:4];
        if (lo == 4'd9) begin
            lo = 4'd0;
            hi = (hi == 4'd9) ? 4'd0 : hi + 4'd1;
        end else begin
            lo = lo + 4'd1;
        end
        return {hi, lo};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Wait for the next CLEAR cycle, i.e. just after a fresh LATCH.
    task automatic wait_result();
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 300 && !ok; k++) begin
            @(negedge clk);
            if (clr && k > 0) ok = 1'b1;
        end
        if (!ok) check("wait_result_timeout", 32'd0, 32'd1);
    endtask

    // Square-wave generator for the measured signal.
    initial begin
        forever begin
            @(negedge clk);
            if (period != 0) begin
                ph = (ph + 1 >= period) ? 0 : ph + 1;
                gen_sig = (ph < period / 2);
            end
        end
    end

    // Downstream decade counter model: reacts to pre-edge enable/clear.
    initial begin
        logic c;
        logic e;
        forever begin
            @(negedge clk);
            c = clr;
            e = en;
            @(posedge clk);
            #1;
            if (c) digits = 8'h00;
            else if (e) digits = bcd_inc(digits);
        end
    end

    initial begin
        int n;
        repeat (3) @(negedge clk);
        #1;
        check("rst_clear", 32'(clr), 32'd1);
        check("rst_enable", 32'(en), 32'd0);
        check("rst_result", 32'(result), 32'h00);
        check("rst_ovf", 32'(ovf), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);

        // Release: cycle 0 is CLEAR, LATCH at cycle 102.
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("cyc0_clear", 32'(clr), 32'd1);
        @(posedge clk); #1;
        check("cyc1_clear", 32'(clr), 32'd0);
        repeat (101) @(posedge clk);
        #1;
        check("cyc102_valid", 32'(valid), 32'd0);
        check("cyc102_clear", 32'(clr), 32'd0);
        @(posedge clk); #1;
        check("latch1_valid", 32'(valid), 32'd1);
        check("latch1_result", 32'(result), 32'h00);
        check("latch1_ovf", 32'(ovf), 32'd0);
        check("period_clear", 32'(clr), 32'd1);

        // Edge-to-enable latency of three cycles, inside GATE.
        repeat (10) @(posedge clk);
        @(negedge clk);
        man_sig = 1'b1;
        @(posedge clk); #1;
        check("lat_c1", 32'(en), 32'd0);
        @(posedge clk); #1;
        check("lat_c2", 32'(en), 32'd0);
        @(posedge clk); #1;
        check("lat_c3", 32'(en), 32'd1);
        @(posedge clk); #1;
        check("lat_c4", 32'(en), 32'd0);
        wait_result();
        check("single_edge_result", 32'(result), 32'h01);
        man_sig = 1'b0;

        // Period 10 -> 10 edges per gate.
        period = 10;
        wait_result();
        wait_result();
        check("p10_result_a", 32'(result), 32'h10);
        check("p10_ovf_a", 32'(ovf), 32'd0);
        wait_result();
        check("p10_result_b", 32'(result), 32'h10);

        // Period 2 -> 50 edges per gate.
        period = 2;
        wait_result();
        wait_result();
        check("p2_result", 32'(result), 32'h50);

        // Forced carry during GATE -> overflow, then cleared next time.
        period = 10;
        wait_result();
        repeat (30) @(negedge clk);
        force_carry = 1'b1;
        repeat (20) @(negedge clk);
        force_carry = 1'b0;
        wait_result();
        check("ovf_set", 32'(ovf), 32'd1);
        check("ovf_result", 32'(result), 32'h10);
        wait_result();
        check("ovf_cleared", 32'(ovf), 32'd0);
        check("ovf_next_result", 32'(result), 32'h10);
        check("valid_held", 32'(valid), 32'd1);

        // One-cycle ready outside LATCH -> valid drops next cycle.
        ready = 1'b1;
        @(posedge clk); #1;
        check("hs_valid_clear", 32'(valid), 32'd0);
        @(negedge clk);
        ready = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("hs_valid_stays0", 32'(valid), 32'd0);
        wait_result();
        check("relatch_valid", 32'(valid), 32'd1);

        // Ready coinciding with LATCH -> valid stays 1 with new data.
        repeat (102) @(posedge clk);
        @(negedge clk);
        ready = 1'b1;
        @(posedge clk); #1;
        check("hs_latch_valid", 32'(valid), 32'd1);
        check("hs_latch_clear", 32'(clr), 32'd1);
        @(negedge clk);
        ready = 1'b0;
        check("hs_latch_valid_hold", 32'(valid), 32'd1);

        // Reset at GATE cycle 50 -> immediate reset values, LATCH 103 after release.
        repeat (50) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_clear", 32'(clr), 32'd1);
        check("mid_rst_enable", 32'(en), 32'd0);
        check("mid_rst_valid", 32'(valid), 32'd0);
        check("mid_rst_result", 32'(result), 32'h00);
        check("mid_rst_ovf", 32'(ovf), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            n++;
            if (valid) break;
        end
        check("post_rst_latch_cycles", 32'(n), 32'd103);
        check("post_rst_result", 32'(result), 32'h10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
